// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter for the mouse port. Sends one
//               command byte (e.g. 0xF4 enable reporting, 0xFF reset) by
//               inhibiting the bus, issuing a start bit, shifting the frame on
//               device-generated falling clock edges and checking the ack.
//               The lines are driven open-drain via output enables; the top
//               level owns the tri-state buffers.
// Ports       : clk          - system clock (65 MHz domain)
//               rst          - asynchronous reset, active low
//               tx_valid     - request to send tx_data
//               tx_data[7:0] - command byte, sampled only at accept
//               tx_ready     - high when idle; accept = tx_valid && tx_ready
//               ps2_clk_i    - raw PS/2 clock line level (asynchronous)
//               ps2_data_i   - raw PS/2 data line level (asynchronous)
//               ps2_clk_oe   - 1 pulls the clock line low, 0 releases it
//               ps2_data_oe  - 1 pulls the data line low, 0 releases it
//               done         - one-cycle pulse, byte acknowledged by device
//               err          - one-cycle pulse, no ack or timeout
//               busy         - inverse of tx_ready
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 6500,
    parameter int START_SETUP_CYCLES = 650,
    parameter int TIMEOUT_CYCLES     = 975000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err,
    output logic       busy
);

    // One shared counter serves all three phases, so size it for the largest.
    localparam int c_MAX_A      = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES : START_SETUP_CYCLES;
    localparam int c_MAX_CYCLES = (c_MAX_A > TIMEOUT_CYCLES) ? c_MAX_A : TIMEOUT_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST   = c_CNT_W'(START_SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_INHIBIT   = 3'd1;
    localparam logic [2:0] c_START     = 3'd2;
    localparam logic [2:0] c_SEND      = 3'd3;
    localparam logic [2:0] c_ACK       = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [9:0]         r_frame;
    logic [3:0]         r_bitcnt;
    logic               r_clk_meta;
    logic               r_clk_sync;
    logic               r_clk_prev;
    logic               r_data_meta;
    logic               r_data_sync;
    logic               r_fe;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_done;
    logic               r_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_timeout;

    // Holding ready low during the done/err pulse makes it rise one cycle
    // after the pulse, so a new request never overlaps a completion report.
    assign w_ready   = (r_state == c_IDLE) && !r_done && !r_err;
    assign w_accept  = tx_valid && w_ready;
    assign w_timeout = (r_cnt == c_TIMEOUT_LAST);

    assign tx_ready    = w_ready;
    assign busy        = ~w_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign err         = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Idle bus level is high, so the synchronisers start there too.
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_fe        <= 1'b0;
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_frame     <= '0;
            r_bitcnt    <= '0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
            r_fe        <= r_clk_prev & ~r_clk_sync;
            r_done      <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_frame   <= {1'b1, ~^tx_data, tx_data};
                        r_bitcnt  <= '0;
                        r_cnt     <= '0;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_state   <= c_INHIBIT;
                    end
                end

                // Falling edges seen while we hold the clock low are ignored.
                c_INHIBIT: begin
                    if (r_cnt == c_INHIBIT_LAST) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;
                        r_state   <= c_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_START: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b0;
                        r_state  <= c_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_SEND, c_ACK, c_WAIT_IDLE: begin
                    // Timeout spans release-to-idle and also covers a device
                    // that never starts clocking; any partial frame is dropped.
                    if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_state == c_SEND) begin
                            if (r_fe) begin
                                r_data_oe <= ~r_frame[r_bitcnt];
                                r_bitcnt  <= r_bitcnt + 1'b1;
                                if (r_bitcnt == 4'd9) begin
                                    r_state <= c_ACK;
                                end
                            end
                        end else if (r_state == c_ACK) begin
                            r_data_oe <= 1'b0;
                            if (r_fe) begin
                                if (!r_data_sync) begin
                                    r_state <= c_WAIT_IDLE;
                                end else begin
                                    r_err   <= 1'b1;
                                    r_state <= c_IDLE;
                                end
                            end
                        end else begin
                            if (r_clk_sync && r_data_sync) begin
                                r_done  <= 1'b1;
                                r_state <= c_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx. A behavioural PS/2
//               device drives the wired-AND bus lines, collects the bits the
//               host presents on rising clock edges and answers with (or
//               withholds) the ack. Expected frames are computed from the
//               command byte with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH   = 40;
    localparam int SETUP = 10;
    localparam int TMO   = 1500;
    localparam int HALF  = 20;
    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, err, busy;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    // Open-drain bus: either side can pull a line low.
    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_SETUP_CYCLES(SETUP),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (clk_line),
        .ps2_data_i (data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         viol     = 0;
    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    int         done_cyc[$];

    always @(posedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            acc_q.push_back(tx_data);
            acc_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
        end
        if (err) err_cnt = err_cnt + 1;
        if ((done && err) || ((done || err) && tx_ready)) viol = viol + 1;
    end

    // Line levels the device should see on rising edges 1..10.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = 1'((d >> i) & 8'd1);
        f[8] = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic dev_frame(input bit ack, output logic [9:0] bits,
                             output int t0, output int t1, output int t2, output bit ok);
        ok = 1'b1; bits = '0; t0 = 0; t1 = 0; t2 = 0;
        for (int k = 0; k < LIMIT && ps2_clk_oe !== 1'b1; k++) @(negedge clk);
        t0 = cyc;
        for (int k = 0; k < LIMIT && ps2_data_oe !== 1'b1; k++) @(negedge clk);
        t1 = cyc;
        for (int k = 0; k < LIMIT && ps2_clk_oe !== 1'b0; k++) @(negedge clk);
        t2 = cyc;
        if (ps2_data_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            bits[i] = data_line;
            repeat (HALF) @(negedge clk);
        end
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic run_transfer(input logic [7:0] d, input bit ack, input string name);
        int         d0, e0, v0, t0, t1, t2;
        bit         ok;
        logic [9:0] bits, exp;
        d0 = done_cnt; e0 = err_cnt; v0 = viol;
        exp = model_frame(d);
        fork
            begin
                @(negedge clk);
                tx_valid = 1'b1; tx_data = d;
                @(negedge clk);
                tx_valid = 1'b0; tx_data = 8'($urandom);
            end
            dev_frame(ack, bits, t0, t1, t2, ok);
        join
        for (int k = 0; k < 200 && done_cnt == d0 && err_cnt == e0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s bus_phase: got %0d want 1", name, ok); end
        n_checks++; if (t1 - t0 !== INH) begin n_fail++; $display("FAIL %s inhibit_len: got %0d want %0d", name, t1 - t0, INH); end
        n_checks++; if (t2 - t1 !== SETUP) begin n_fail++; $display("FAIL %s setup_len: got %0d want %0d", name, t2 - t1, SETUP); end
        n_checks++; if (bits !== exp) begin n_fail++; $display("FAIL %s frame: got %b want %b", name, bits, exp); end
        n_checks++; if (done_cnt - d0 !== (ack ? 1 : 0)) begin n_fail++; $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt - d0, ack ? 1 : 0); end
        n_checks++; if (err_cnt - e0 !== (ack ? 0 : 1)) begin n_fail++; $display("FAIL %s err_pulses: got %0d want %0d", name, err_cnt - e0, ack ? 0 : 1); end
        n_checks++; if (viol !== v0) begin n_fail++; $display("FAIL %s pulse_overlap: got %0d want %0d", name, viol - v0, 0); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready_after: got %b want 1", name, tx_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset clk_oe: got %b want 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset data_oe: got %b want 0", ps2_data_oe); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset done_err: got %b want 00", {done, err}); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_f4();
        run_transfer(8'hF4, 1'b1, "send_f4");
    endtask

    task automatic test_parity();
        run_transfer(8'h00, 1'b1, "send_00");
        run_transfer(8'hFF, 1'b1, "send_ff");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) run_transfer(8'($urandom), 1'b1, "send_rand");
    endtask

    task automatic test_no_ack();
        run_transfer(8'($urandom), 1'b0, "no_ack");
    endtask

    task automatic test_timeout();
        int d0, e0, t2, te;
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hF4;
        @(negedge clk); tx_valid = 1'b0;
        for (int k = 0; k < LIMIT && ps2_clk_oe !== 1'b1; k++) @(negedge clk);
        for (int k = 0; k < LIMIT && ps2_clk_oe !== 1'b0; k++) @(negedge clk);
        t2 = cyc;
        for (int k = 0; k < TMO + 100 && err !== 1'b1; k++) @(negedge clk);
        te = cyc;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout err_seen: got %b want 1", err); end
        n_checks++; if (te - t2 !== TMO) begin n_fail++; $display("FAIL timeout latency: got %0d want %0d", te - t2, TMO); end
        n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL timeout oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL timeout ready_next: got %b want 1", tx_ready); end
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt !== d0 || err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout pulses: got done %0d err %0d want 0 1", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        fork
            begin
                @(negedge clk); tx_valid = 1'b1; tx_data = 8'hF4;
                @(negedge clk); tx_valid = 1'b0;
            end
            begin
                for (int k = 0; k < LIMIT && ps2_clk_oe !== 1'b1; k++) @(negedge clk);
                for (int k = 0; k < LIMIT && ps2_clk_oe !== 1'b0; k++) @(negedge clk);
                repeat (10) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    dev_clk = 1'b0; repeat (HALF) @(negedge clk);
                    dev_clk = 1'b1; repeat (HALF) @(negedge clk);
                end
                // Fourth falling edge: host now presents bit 3 of 0xF4 (a 0).
                dev_clk = 1'b0;
                repeat (HALF / 2) @(negedge clk);
            end
        join
        n_checks++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL midrst data_before: got %b want 1", ps2_data_oe); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_fail++; $display("FAIL midrst oe_async: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst tx_ready: got %b want 1", tx_ready); end
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_transfer(8'hF4, 1'b1, "after_rst");
    endtask

    task automatic test_back_to_back();
        int         a0, dc0, t0, t1, t2;
        bit         ok1, ok2;
        logic [9:0] b1, b2;
        logic [7:0] first;
        first = 8'($urandom);
        a0 = acc_q.size(); dc0 = done_cyc.size();
        fork
            begin
                @(negedge clk); tx_valid = 1'b1; tx_data = first;
                for (int k = 0; k < LIMIT && acc_q.size() < a0 + 2; k++) begin
                    @(negedge clk); tx_data = 8'($urandom);
                end
                tx_valid = 1'b0;
            end
            begin
                dev_frame(1'b1, b1, t0, t1, t2, ok1);
                dev_frame(1'b1, b2, t0, t1, t2, ok2);
            end
        join
        for (int k = 0; k < 200 && done_cyc.size() < dc0 + 2; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL b2b bus_phase: got %b want 11", {ok1, ok2}); end
        n_checks++;
        if (acc_q.size() - a0 !== 2 || done_cyc.size() - dc0 !== 2) begin
            n_fail++;
            $display("FAIL b2b counts: got accepts %0d dones %0d want 2 2", acc_q.size() - a0, done_cyc.size() - dc0);
        end else begin
            n_checks++; if (acc_q[a0] !== first) begin n_fail++; $display("FAIL b2b first_byte: got %h want %h", acc_q[a0], first); end
            n_checks++; if (b1 !== model_frame(first)) begin n_fail++; $display("FAIL b2b frame1: got %b want %b", b1, model_frame(first)); end
            n_checks++; if (b2 !== model_frame(acc_q[a0 + 1])) begin n_fail++; $display("FAIL b2b frame2: got %b want %b", b2, model_frame(acc_q[a0 + 1])); end
            n_checks++; if (acc_cyc[a0 + 1] <= done_cyc[dc0]) begin n_fail++; $display("FAIL b2b accept_order: got accept %0d want after done %0d", acc_cyc[a0 + 1], done_cyc[dc0]); end
        end
    endtask

    initial begin
        test_reset();
        test_send_f4();
        test_parity();
        test_random();
        test_no_ack();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
